br_flow_checks_valid_data: RTL and testbench

// Synthesizable protocol checker for NumFlows parallel ready-valid push interfaces.

---
 rtl/br_flow_checks_pkg.sv | 19 +
 rtl/br_flow_checks_valid_data_lane.sv | 89 ++++++++
 rtl/br_flow_checks_valid_data.sv | 82 ++++++++
 tb/tb_br_flow_checks_valid_data.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/br_flow_checks_pkg.sv
// Shared types for the ready-valid flow checkers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// flow_chk_flags_t groups the three per-flow conditions a checker lane tracks,
// used both for the error set and for the cover set of a lane.
package br_flow_checks_pkg;

  typedef struct packed {
    logic valid_unstable;
    logic data_unstable;
    logic backpressure;
  } flow_chk_flags_t;

  localparam flow_chk_flags_t FLAGS_CLEAR = '{valid_unstable: 1'b0,
                                              data_unstable:  1'b0,
                                              backpressure:   1'b0};

endpackage

// File: rtl/br_flow_checks_valid_data_lane.sv
// One-flow ready-valid protocol checker lane: history regs plus event detection.
// Latency: an event in cycle t sets its sticky flag at the edge ending t; visible from t+1.
// Backpressure: passive observer, never stalls; backpressure itself is only detected.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   valid/ready  this flow's handshake signals
//   data         this flow's payload
//   err_flags    sticky error flags (only the enabled checks can set them)
//   cov_flags    sticky cover flags
module br_flow_checks_valid_data_lane
  import br_flow_checks_pkg::*;
#(
  parameter int Width                      = 1,
  parameter int EnableCoverBackpressure    = 1,
  parameter int EnableAssertValidStability = 1,
  parameter int EnableAssertDataStability  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             ready,
  input  logic [Width-1:0] data,
  output flow_chk_flags_t  err_flags,
  output flow_chk_flags_t  cov_flags
);

  localparam bit EnBpErr    = (EnableCoverBackpressure == 0);
  localparam bit EnValidErr = (EnableAssertValidStability != 0);
  localparam bit EnDataErr  = (EnableAssertDataStability != 0);

  logic             valid_q;
  logic             ready_q;
  logic [Width-1:0] data_q;
  logic             stall_q;

  logic            ev_bp;
  logic            ev_valid_drop;
  logic            ev_data_change;
  flow_chk_flags_t err_set;
  flow_chk_flags_t cov_set;
  flow_chk_flags_t err_q;
  flow_chk_flags_t cov_q;

  // Previous cycle offered a beat that was not taken.
  assign stall_q = valid_q & ~ready_q;

  always_comb begin
    ev_bp          = valid & ~ready;
    ev_valid_drop  = stall_q & ~valid;
    // Gated on valid so that a valid drop is never double-reported as a data change.
    ev_data_change = stall_q & valid & (data != data_q);

    err_set                = FLAGS_CLEAR;
    err_set.valid_unstable = ev_valid_drop & EnValidErr;
    err_set.data_unstable  = ev_data_change & EnDataErr;
    err_set.backpressure   = ev_bp & EnBpErr;

    cov_set                = FLAGS_CLEAR;
    cov_set.valid_unstable = ev_valid_drop & ~EnValidErr;
    cov_set.data_unstable  = ev_data_change & ~EnDataErr;
    // Backpressure is always covered, even when it is also an error.
    cov_set.backpressure   = ev_bp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      err_q   <= FLAGS_CLEAR;
      cov_q   <= FLAGS_CLEAR;
    end else begin
      valid_q <= valid;
      ready_q <= ready;
      data_q  <= data;
      err_q.valid_unstable <= err_q.valid_unstable | err_set.valid_unstable;
      err_q.data_unstable  <= err_q.data_unstable  | err_set.data_unstable;
      err_q.backpressure   <= err_q.backpressure   | err_set.backpressure;
      cov_q.valid_unstable <= cov_q.valid_unstable | cov_set.valid_unstable;
      cov_q.data_unstable  <= cov_q.data_unstable  | cov_set.data_unstable;
      cov_q.backpressure   <= cov_q.backpressure   | cov_set.backpressure;
    end
  end

  assign err_flags = err_q;
  assign cov_flags = cov_q;

endmodule

// File: rtl/br_flow_checks_valid_data.sv
// Protocol checker for NumFlows parallel ready-valid push interfaces.
// Latency: sticky flags visible the cycle after the offending cycle; err_any adds no latency.
// Backpressure: passive observer, never stalls; checks valid/data stability under backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ready/valid/data    per-flow handshake and payload, data packed [NumFlows-1:0][Width-1:0]
//   end_of_test         environment's final-cycle indicator
//   err_*               sticky per-flow errors, err_final_valid global
//   cov_*               sticky per-flow covers
//   err_any             OR of every err_* bit
module br_flow_checks_valid_data
  import br_flow_checks_pkg::*;
#(
  parameter int NumFlows                   = 1,
  parameter int Width                      = 1,
  parameter int EnableCoverBackpressure    = 1,
  parameter int EnableAssertValidStability = 1,
  parameter int EnableAssertDataStability  = 1,
  parameter int EnableAssertFinalNotValid  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NumFlows-1:0]            ready,
  input  logic [NumFlows-1:0]            valid,
  input  logic [NumFlows-1:0][Width-1:0] data,
  input  logic                           end_of_test,
  output logic [NumFlows-1:0]            err_valid_unstable,
  output logic [NumFlows-1:0]            err_data_unstable,
  output logic [NumFlows-1:0]            err_backpressure,
  output logic                           err_final_valid,
  output logic [NumFlows-1:0]            cov_backpressure,
  output logic [NumFlows-1:0]            cov_valid_unstable,
  output logic [NumFlows-1:0]            cov_data_unstable,
  output logic                           err_any
);

  localparam bit EnFinalErr = (EnableAssertFinalNotValid != 0);

  flow_chk_flags_t lane_err [NumFlows];
  flow_chk_flags_t lane_cov [NumFlows];
  logic            err_final_q;

  for (genvar i = 0; i < NumFlows; i++) begin : g_lane
    br_flow_checks_valid_data_lane #(
      .Width                      (Width),
      .EnableCoverBackpressure    (EnableCoverBackpressure),
      .EnableAssertValidStability (EnableAssertValidStability),
      .EnableAssertDataStability  (EnableAssertDataStability)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (valid[i]),
      .ready     (ready[i]),
      .data      (data[i]),
      .err_flags (lane_err[i]),
      .cov_flags (lane_cov[i])
    );

    assign err_valid_unstable[i] = lane_err[i].valid_unstable;
    assign err_data_unstable[i]  = lane_err[i].data_unstable;
    assign err_backpressure[i]   = lane_err[i].backpressure;
    assign cov_valid_unstable[i] = lane_cov[i].valid_unstable;
    assign cov_data_unstable[i]  = lane_cov[i].data_unstable;
    assign cov_backpressure[i]   = lane_cov[i].backpressure;
  end

  // Any flow still offering while the environment says the test is over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_final_q <= 1'b0;
    end else begin
      err_final_q <= err_final_q | (EnFinalErr & end_of_test & (|valid));
    end
  end

  assign err_final_valid = err_final_q;

  assign err_any = (|err_valid_unstable) | (|err_data_unstable) |
                   (|err_backpressure) | err_final_valid;

endmodule

// File: tb/tb_br_flow_checks_valid_data.sv
module tb_br_flow_checks_valid_data;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      ready;
  logic [1:0]      valid;
  logic [1:0][7:0] data;
  logic            end_of_test;

  int n_cmp = 0;
  int n_err = 0;

  // a: all checks as errors, backpressure covered
  // b: backpressure is an error, final check disabled
  // c: valid/data instability covered instead of errored
  logic [1:0] a_evu, a_edu, a_ebp, a_cbp, a_cvu, a_cdu;
  logic       a_efv, a_any;
  logic [1:0] b_evu, b_edu, b_ebp, b_cbp, b_cvu, b_cdu;
  logic       b_efv, b_any;
  logic [1:0] c_evu, c_edu, c_ebp, c_cbp, c_cvu, c_cdu;
  logic       c_efv, c_any;

  always #5 clk = ~clk;

  br_flow_checks_valid_data #(.NumFlows(2), .Width(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ready(ready), .valid(valid), .data(data),
    .end_of_test(end_of_test),
    .err_valid_unstable(a_evu), .err_data_unstable(a_edu), .err_backpressure(a_ebp),
    .err_final_valid(a_efv), .cov_backpressure(a_cbp), .cov_valid_unstable(a_cvu),
    .cov_data_unstable(a_cdu), .err_any(a_any));

  br_flow_checks_valid_data #(.NumFlows(2), .Width(8), .EnableCoverBackpressure(0),
                              .EnableAssertFinalNotValid(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(ready), .valid(valid), .data(data),
    .end_of_test(end_of_test),
    .err_valid_unstable(b_evu), .err_data_unstable(b_edu), .err_backpressure(b_ebp),
    .err_final_valid(b_efv), .cov_backpressure(b_cbp), .cov_valid_unstable(b_cvu),
    .cov_data_unstable(b_cdu), .err_any(b_any));

  br_flow_checks_valid_data #(.NumFlows(2), .Width(8), .EnableAssertValidStability(0),
                              .EnableAssertDataStability(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .ready(ready), .valid(valid), .data(data),
    .end_of_test(end_of_test),
    .err_valid_unstable(c_evu), .err_data_unstable(c_edu), .err_backpressure(c_ebp),
    .err_final_valid(c_efv), .cov_backpressure(c_cbp), .cov_valid_unstable(c_cvu),
    .cov_data_unstable(c_cdu), .err_any(c_any));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_a"}, {18'b0, a_evu, a_edu, a_ebp, a_efv, a_cbp, a_cvu, a_cdu, a_any}, 32'h0);
    chk({tag, "_b"}, {18'b0, b_evu, b_edu, b_ebp, b_efv, b_cbp, b_cvu, b_cdu, b_any}, 32'h0);
    chk({tag, "_c"}, {18'b0, c_evu, c_edu, c_ebp, c_efv, c_cbp, c_cvu, c_cdu, c_any}, 32'h0);
  endtask

  // Reset pulse in the middle of a cycle; outputs must clear without a clock edge.
  task automatic pulse_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #2;
    all_zero(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    ready       = 2'b00;
    valid       = 2'b00;
    data        = '0;
    end_of_test = 1'b0;
    #23;
    all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Flow 0 stalls 3 cycles with data held, then handshakes.
    valid = 2'b01; ready = 2'b00; data[0] = 8'hA5;
    tick();
    chk("t1_cov_bp_first", a_cbp, 2'b01);
    tick(); tick();
    ready = 2'b01;
    tick();
    valid = 2'b00; ready = 2'b00;
    tick();
    chk("t1_a_cov_bp", a_cbp, 2'b01);
    chk("t1_a_err_any", a_any, 1'b0);
    chk("t1_a_err_vec", {a_evu, a_edu, a_ebp, a_efv}, 7'b0);
    chk("t1_b_err_bp", b_ebp, 2'b01);
    chk("t1_b_cov_bp", b_cbp, 2'b01);
    chk("t1_b_err_any", b_any, 1'b1);
    pulse_reset("rst1");

    // Flow 1 drops valid while stalled.
    valid = 2'b10; ready = 2'b00; data[1] = 8'h5A;
    tick();
    valid = 2'b00;
    chk("t2_before", a_evu, 2'b00);
    tick();
    chk("t2_a_err_vu", a_evu, 2'b10);
    chk("t2_a_err_any", a_any, 1'b1);
    chk("t2_a_cov_vu", a_cvu, 2'b00);
    chk("t2_a_no_du", a_edu, 2'b00);
    chk("t2_c_cov_vu", c_cvu, 2'b10);
    chk("t2_c_err_vu", c_evu, 2'b00);
    chk("t2_c_err_any", c_any, 1'b0);
    tick();
    chk("t2_a_sticky", a_evu, 2'b10);
    pulse_reset("rst2");

    // Flow 0 changes data while stalled.
    valid = 2'b01; ready = 2'b00; data[0] = 8'h11;
    tick();
    data[0] = 8'h22;
    tick();
    chk("t3_a_err_du", a_edu, 2'b01);
    chk("t3_a_err_vu", a_evu, 2'b00);
    chk("t3_c_cov_du", c_cdu, 2'b01);
    chk("t3_c_err_du", c_edu, 2'b00);
    chk("t3_c_err_any", c_any, 1'b0);
    valid = 2'b00;
    pulse_reset("rst3");

    // Same data change right after a handshake is legal.
    valid = 2'b01; ready = 2'b01; data[0] = 8'h11;
    tick();
    data[0] = 8'h22; ready = 2'b00;
    tick();
    tick();
    chk("t3_hs_a_du", a_edu, 2'b00);
    chk("t3_hs_a_any", a_any, 1'b0);
    chk("t3_hs_c_cdu", c_cdu, 2'b00);
    valid = 2'b00;
    pulse_reset("rst4");

    // Backpressure as an error: handshakes only, then one stall on flow 0.
    valid = 2'b11; ready = 2'b11;
    tick(); tick();
    chk("t4_hs_b_ebp", b_ebp, 2'b00);
    chk("t4_hs_b_cbp", b_cbp, 2'b00);
    ready = 2'b10;
    chk("t4_before", b_ebp, 2'b00);
    tick();
    chk("t4_b_ebp", b_ebp, 2'b01);
    chk("t4_a_ebp", a_ebp, 2'b00);
    chk("t4_a_cbp", a_cbp, 2'b01);
    valid = 2'b00;
    pulse_reset("rst5");

    // End of test with a valid still high.
    end_of_test = 1'b1; valid = 2'b10; ready = 2'b11;
    tick();
    chk("t5_a_efv", a_efv, 1'b1);
    chk("t5_a_any", a_any, 1'b1);
    chk("t5_b_efv", b_efv, 1'b0);
    valid = 2'b00;
    pulse_reset("rst6");
    end_of_test = 1'b1; valid = 2'b00;
    tick();
    chk("t5_idle_a_efv", a_efv, 1'b0);
    end_of_test = 1'b0;

    // Stall recorded in history, then reset; a post-reset valid drop is not an event.
    valid = 2'b01; ready = 2'b00; data[0] = 8'h33;
    tick();
    pulse_reset("rst7");
    valid = 2'b00;
    tick();
    chk("t6_a_evu", a_evu, 2'b00);
    chk("t6_c_cvu", c_cvu, 2'b00);
    chk("t6_a_any", a_any, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
